// File: rtl/coreriscv_axi4_meta_resp_router_pkg.sv
// Shared types for the metadata response router.
// Requester IDs and metadata index widths.
package coreriscv_axi4_meta_resp_router_pkg;

    localparam int REQ_ID_W   = 2;
    localparam int NUM_REQ    = 3;
    localparam int META_IDX_W = 7;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t ID_INVALID = 2'h3;

endpackage

// File: rtl/coreriscv_axi4_meta_resp_router_id_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Push is ignored when full, pop is ignored when empty.
module coreriscv_axi4_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state: storage write, pointer advance, occupancy update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; contents need no reset, pointers and count do.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/coreriscv_axi4_meta_resp_router.sv
// Return-path router for the metadata array.
// Tracks requester IDs in order and steers responses back.
module coreriscv_axi4_meta_resp_router
    import coreriscv_axi4_meta_resp_router_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 20,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_in_valid,
    output logic                  req_in_ready,
    input  logic [META_IDX_W-1:0] req_in_bits_idx,
    input  logic                  req_in_bits_way_en,
    input  logic [REQ_ID_W-1:0]   req_in_chosen,
    output logic                  req_out_valid,
    input  logic                  req_out_ready,
    output logic [META_IDX_W-1:0] req_out_bits_idx,
    output logic                  req_out_bits_way_en,
    input  logic                  resp_in_valid,
    output logic                  resp_in_ready,
    input  logic [DATA_W-1:0]     resp_in_bits_data,
    output logic                  resp_0_valid,
    output logic                  resp_1_valid,
    output logic                  resp_2_valid,
    input  logic                  resp_0_ready,
    input  logic                  resp_1_ready,
    input  logic                  resp_2_ready,
    output logic [DATA_W-1:0]     resp_bits_data,
    output logic [CNT_W-1:0]      in_flight,
    output logic                  err_orphan,
    output logic                  err_bad_id
);

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    req_id_t              head;
    logic [NUM_REQ-1:0]   resp_valid;
    logic                 err_orphan_q, err_orphan_d;
    logic                 err_bad_id_q, err_bad_id_d;

    // Request side never looks at the response side: full alone gates it.
    assign req_out_valid       = req_in_valid & ~full;
    assign req_in_ready        = req_out_ready & ~full;
    assign req_out_bits_idx    = req_in_bits_idx;
    assign req_out_bits_way_en = req_in_bits_way_en;
    assign push                = req_in_valid & req_in_ready;

    coreriscv_axi4_id_fifo #(
        .WIDTH (REQ_ID_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (req_in_chosen),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (in_flight)
    );

    // Steer response to head requester; drop when empty or head is invalid.
    always_comb begin
        resp_valid    = '0;
        resp_in_ready = 1'b1;
        if (!empty) begin
            case (head)
                2'd0: begin
                    resp_valid[0] = resp_in_valid;
                    resp_in_ready = resp_0_ready;
                end
                2'd1: begin
                    resp_valid[1] = resp_in_valid;
                    resp_in_ready = resp_1_ready;
                end
                2'd2: begin
                    resp_valid[2] = resp_in_valid;
                    resp_in_ready = resp_2_ready;
                end
                default: begin
                    resp_valid    = '0;
                    resp_in_ready = 1'b1;
                end
            endcase
        end
    end

    assign pop            = resp_in_valid & resp_in_ready & ~empty;
    assign resp_0_valid   = resp_valid[0];
    assign resp_1_valid   = resp_valid[1];
    assign resp_2_valid   = resp_valid[2];
    assign resp_bits_data = resp_in_bits_data;

    // Sticky protocol error detection.
    always_comb begin
        err_orphan_d = err_orphan_q | (resp_in_valid & empty);
        err_bad_id_d = err_bad_id_q | (push & (req_in_chosen == ID_INVALID));
    end

    // Error flags clear only on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_orphan_q <= 1'b0;
            err_bad_id_q <= 1'b0;
        end else begin
            err_orphan_q <= err_orphan_d;
            err_bad_id_q <= err_bad_id_d;
        end
    end

    assign err_orphan = err_orphan_q;
    assign err_bad_id = err_bad_id_q;

endmodule
